// File: rtl/serial_to_parallel_aligner_pkg.sv
// Shared definitions for the serial-to-parallel byte aligner:
// default symbol geometry, the COM/idle symbol and the lane state encoding.
package serial_to_parallel_aligner_pkg;

  localparam int         WIDTH_DEF     = 8;
  localparam logic [7:0] COM_DEF       = 8'hBC;
  localparam int         COM_COUNT_DEF = 4;

  // Lane alignment states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_to_parallel_aligner.sv
// Serial-to-parallel aligner: rebuilds MSB-first bytes from a 1-bit stream,
// hunts for the COM symbol at any bit offset, confirms COM_COUNT consecutive
// byte-aligned COMs, then presents every completed byte in parallel.
module serial_to_parallel_aligner
  import serial_to_parallel_aligner_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_DEF),
  parameter int               COM_COUNT = COM_COUNT_DEF
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_stb,
  output logic             active
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CC_W  = $clog2(COM_COUNT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CC_W-1:0]  COM_LAST = CC_W'(COM_COUNT - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CC_W-1:0]  com_cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             out_stb_q;
  logic             active_q;

  logic [WIDTH-1:0] nxt_d;
  logic             boundary_d;
  logic             is_com_d;

  // Byte being completed this cycle and whether this edge closes a symbol.
  always_comb begin
    nxt_d      = {sr_q[WIDTH-2:0], in};
    boundary_d = (bit_cnt_q == BIT_LAST);
    is_com_d   = (nxt_d == COM);
  end

  // Shift register, bit/COM counters, alignment FSM and registered outputs.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      com_cnt_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_stb_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      sr_q      <= nxt_d;
      out_stb_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          // Phase is unknown here, so the counter is parked until a COM is seen.
          bit_cnt_q <= '0;
          if (is_com_d) begin
            com_cnt_q <= CC_W'(1);
            if (COM_COUNT <= 1) begin
              // A single COM is enough to lock; present it like any lock symbol.
              state_q     <= ST_ACTIVE;
              active_q    <= 1'b1;
              out_q       <= nxt_d;
              out_valid_q <= 1'b0;
              out_stb_q   <= 1'b1;
            end else begin
              state_q <= ST_ALIGN;
            end
          end else begin
            com_cnt_q <= '0;
          end
        end
        ST_ALIGN: begin
          bit_cnt_q <= boundary_d ? '0 : bit_cnt_q + CNT_W'(1);
          if (boundary_d) begin
            if (is_com_d) begin
              com_cnt_q <= com_cnt_q + CC_W'(1);
              if (com_cnt_q == COM_LAST) begin
                // Lock: the final COM is shown as a non-valid strobed symbol.
                state_q     <= ST_ACTIVE;
                active_q    <= 1'b1;
                out_q       <= nxt_d;
                out_valid_q <= 1'b0;
                out_stb_q   <= 1'b1;
              end
            end else begin
              com_cnt_q <= '0;
              state_q   <= ST_HUNT;
            end
          end
        end
        ST_ACTIVE: begin
          // Locked for good: every boundary is presented, COM fill flagged not valid.
          bit_cnt_q <= boundary_d ? '0 : bit_cnt_q + CNT_W'(1);
          if (boundary_d) begin
            out_q       <= nxt_d;
            out_valid_q <= ~is_com_d;
            out_stb_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_HUNT;
          bit_cnt_q <= '0;
          com_cnt_q <= '0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_stb   = out_stb_q;
  assign active    = active_q;

endmodule
